// File: rtl/lcd_msg_scheduler.sv
// lcd_msg_scheduler: shares one character-LCD controller between several status
// requesters. After reset it runs the power-up init sequence, then serves requests
// round-robin; each grant clears the display and writes one line from a message ROM.
module lcd_msg_scheduler #(
  parameter int NUM_REQ    = 3,
  parameter int MSG_W      = 2,
  parameter int CHARS      = 16,
  parameter int CLEAR_WAIT = 76000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*MSG_W-1:0] req_msg,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic                     busy,
  output logic                     init_done,
  output logic [8:0]               lcd_inst,
  output logic                     lcd_valid,
  input  logic                     lcd_ready
);

  localparam int CNT_W = (CLEAR_WAIT > 0) ? $clog2(CLEAR_WAIT + 1) : 1;
  localparam int IDX_W = (CHARS > 1) ? $clog2(CHARS) : 1;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((CLEAR_WAIT > 0) ? CLEAR_WAIT - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CHARS - 1);

  localparam logic [127:0] MSG0  = "WAITER READY    ";
  localparam logic [127:0] MSG1  = "MOVING FORWARD  ";
  localparam logic [127:0] MSG2  = "MOVING BACKWARD ";
  localparam logic [127:0] MSG3  = "STOPPED         ";
  localparam logic [127:0] BLANK = {16{8'h20}};

  localparam logic [8:0] CLEAR_CMD = 9'h001;

  typedef enum logic [2:0] {
    INIT_CMD,
    INIT_WAIT,
    IDLE,
    CLEAR,
    CLR_WAIT,
    CHAR
  } state_t;

  state_t             state_q, state_d;
  logic [8:0]         inst_q, inst_d;
  logic               valid_q, valid_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               init_done_q, init_done_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [PTR_W-1:0]   winner_q, winner_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         init_idx_q, init_idx_d;

  logic               wait_done;
  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   grant_next;
  logic [MSG_W-1:0]   grant_msg;

  // Power-up commands: function set, display on, entry increment, clear.
  function automatic logic [8:0] init_code(input logic [1:0] i);
    case (i)
      2'd0:    init_code = 9'h038;
      2'd1:    init_code = 9'h00C;
      2'd2:    init_code = 9'h006;
      default: init_code = CLEAR_CMD;
    endcase
  endfunction

  // Message ROM lookup; IDs or positions beyond the stored text read as spaces.
  function automatic logic [7:0] rom_char(input logic [MSG_W-1:0] msg,
                                          input logic [IDX_W-1:0] idx);
    logic [127:0] line;
    logic [127:0] shifted;
    int           m;
    int           k;
    m = int'(msg);
    k = int'(idx);
    line = BLANK;
    if (m == 0)      line = MSG0;
    else if (m == 1) line = MSG1;
    else if (m == 2) line = MSG2;
    else if (m == 3) line = MSG3;
    if (k < 16) begin
      shifted  = line << (8 * k);
      rom_char = shifted[127:120];
    end else begin
      rom_char = 8'h20;
    end
  endfunction

  assign wait_done = (CLEAR_WAIT == 0) || (wait_q == WAIT_LAST);

  // Round-robin search: first asserted request at or above the pointer, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_next  = '0;
    grant_msg   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_found && req[i] && (i == ((int'(rr_q) + off) % NUM_REQ))) begin
          grant_found = 1'b1;
          grant_idx   = PTR_W'(i);
          grant_next  = PTR_W'((i + 1) % NUM_REQ);
          grant_msg   = req_msg[i*MSG_W +: MSG_W];
        end
      end
    end
  end

  // Next-state logic: an instruction is held until accepted, then valid drops for one
  // cycle before the following instruction is loaded.
  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    valid_d     = valid_q;
    ack_d       = '0;
    init_done_d = init_done_q;
    rr_d        = rr_q;
    winner_d    = winner_q;
    msg_d       = msg_q;
    wait_d      = wait_q;
    idx_d       = idx_q;
    init_idx_d  = init_idx_q;

    case (state_q)
      INIT_CMD: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          inst_d  = init_code(init_idx_q);
        end else if (lcd_ready) begin
          valid_d = 1'b0;
          if (init_idx_q == 2'd3) begin
            init_idx_d = 2'd0;
            if (CLEAR_WAIT == 0) begin
              init_done_d = 1'b1;
              state_d     = IDLE;
            end else begin
              state_d = INIT_WAIT;
            end
          end else begin
            init_idx_d = init_idx_q + 2'd1;
          end
        end
      end

      INIT_WAIT: begin
        if (wait_done) begin
          wait_d      = '0;
          init_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      IDLE: begin
        if (grant_found) begin
          winner_d = grant_idx;
          msg_d    = grant_msg;
          rr_d     = grant_next;
          valid_d  = 1'b1;
          inst_d   = CLEAR_CMD;
          state_d  = CLEAR;
        end
      end

      CLEAR: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          inst_d  = CLEAR_CMD;
        end else if (lcd_ready) begin
          valid_d = 1'b0;
          idx_d   = '0;
          state_d = (CLEAR_WAIT == 0) ? CHAR : CLR_WAIT;
        end
      end

      CLR_WAIT: begin
        if (wait_done) begin
          wait_d  = '0;
          idx_d   = '0;
          valid_d = 1'b1;
          inst_d  = {1'b1, rom_char(msg_q, '0)};
          state_d = CHAR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      CHAR: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          inst_d  = {1'b1, rom_char(msg_q, idx_q)};
        end else if (lcd_ready) begin
          valid_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = IDLE;
            for (int i = 0; i < NUM_REQ; i++) begin
              if (PTR_W'(i) == winner_q) ack_d[i] = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = INIT_CMD;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts everything and restarts the init sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT_CMD;
      inst_q      <= 9'h000;
      valid_q     <= 1'b0;
      ack_q       <= '0;
      init_done_q <= 1'b0;
      rr_q        <= '0;
      winner_q    <= '0;
      msg_q       <= '0;
      wait_q      <= '0;
      idx_q       <= '0;
      init_idx_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
      ack_q       <= ack_d;
      init_done_q <= init_done_d;
      rr_q        <= rr_d;
      winner_q    <= winner_d;
      msg_q       <= msg_d;
      wait_q      <= wait_d;
      idx_q       <= idx_d;
      init_idx_q  <= init_idx_d;
    end
  end

  assign lcd_inst  = inst_q;
  assign lcd_valid = valid_q;
  assign req_ack   = ack_q;
  assign init_done = init_done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// tb_lcd_msg_scheduler: scoreboard bench for lcd_msg_scheduler with a short clear wait.
module tb_lcd_msg_scheduler;

  localparam int NUM_REQ = 3;
  localparam int MSG_W   = 2;
  localparam int CHARS   = 16;
  localparam int CW      = 4;
  localparam int BUDGET  = 3000;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*MSG_W-1:0] req_msg = '0;
  logic                     lcd_ready;
  logic [NUM_REQ-1:0]       req_ack;
  logic                     busy;
  logic                     init_done;
  logic [8:0]               lcd_inst;
  logic                     lcd_valid;

  logic rand_mode = 1'b0;

  int compared = 0;
  int failed = 0;
  int ack_total = 0;
  int xfer_total = 0;
  int msg_char_cnt = 0;

  logic [8:0] expq[$];
  logic [2:0] ackq[$];

  string msg_text[4] = '{"WAITER READY    ", "MOVING FORWARD  ",
                         "MOVING BACKWARD ", "STOPPED         "};

  typedef struct {
    int         req_idx;
    int         msg_id;
    logic [2:0] exp_ack;
  } vec_t;

  vec_t vecs[5];

  lcd_msg_scheduler #(
    .NUM_REQ(NUM_REQ),
    .MSG_W(MSG_W),
    .CHARS(CHARS),
    .CLEAR_WAIT(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_msg(req_msg),
    .req_ack(req_ack),
    .busy(busy),
    .init_done(init_done),
    .lcd_inst(lcd_inst),
    .lcd_valid(lcd_valid),
    .lcd_ready(lcd_ready)
  );

  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Expected instruction stream for one served message: clear, then the 16 characters.
  task automatic pushMessage(input int msg, input logic [2:0] ack);
    string      s;
    logic [7:0] ch;
    s = msg_text[msg];
    expq.push_back(9'h001);
    for (int k = 0; k < CHARS; k++) begin
      ch = s[k];
      expq.push_back({1'b1, ch});
    end
    ackq.push_back(ack);
  endtask

  task automatic pushInit();
    expq.push_back(9'h038);
    expq.push_back(9'h00C);
    expq.push_back(9'h006);
    expq.push_back(9'h001);
  endtask

  task automatic waitAcks(input int target, input string name);
    int n = 0;
    while (ack_total < target && n < BUDGET) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput({name, "_ack_reached"}, 32'(ack_total >= target), 32'd1);
  endtask

  task automatic waitBusy(input string name);
    int n = 0;
    while (!busy && n < BUDGET) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput({name, "_granted"}, 32'(busy), 32'd1);
  endtask

  task automatic waitInit(input string name);
    int n = 0;
    while (!init_done && n < BUDGET) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput({name, "_init_done"}, 32'(init_done), 32'd1);
  endtask

  task automatic waitChars(input int target, input string name);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (msg_char_cnt < target && n < BUDGET);
    checkOutput({name, "_chars_reached"}, 32'(msg_char_cnt >= target), 32'd1);
  endtask

  // Raise one request and register its expected output; optionally check grant latency
  // and drop the request as soon as it has been granted.
  task automatic applyStimulus(input int idx, input int msg, input logic [2:0] exp_ack,
                               input bit check_lat, input bit drop_on_grant);
    pushMessage(msg, exp_ack);
    @(posedge clk); #1;
    req_msg[idx*MSG_W +: MSG_W] = MSG_W'(msg);
    req[idx] = 1'b1;
    if (check_lat) begin
      @(negedge clk);
      checkOutput("lat_before_valid", 32'(lcd_valid), 32'd0);
      checkOutput("lat_before_busy", 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput("lat_valid", 32'(lcd_valid), 32'd1);
      checkOutput("lat_busy", 32'(busy), 32'd1);
      checkOutput("lat_inst", 32'(lcd_inst), 32'h001);
      #1;
    end
    if (drop_on_grant) begin
      waitBusy("drop");
      req[idx] = 1'b0;
    end
  endtask

  // Drive lcd_ready away from the active edge: held high, or random during backpressure.
  initial begin
    lcd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      lcd_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard transfers and acks, handshake stability, ack width, clear gaps.
  initial begin
    int         zero_run;
    logic       prev_stall;
    logic [8:0] prev_inst;
    logic [2:0] prev_ack;
    logic       prev_init;
    logic       last_was_clear;
    logic [8:0] exp_inst;
    zero_run = 0;
    prev_stall = 1'b0;
    prev_inst = '0;
    prev_ack = '0;
    prev_init = 1'b0;
    last_was_clear = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        zero_run = 0;
        prev_stall = 1'b0;
        prev_ack = '0;
        prev_init = 1'b0;
        last_was_clear = 1'b0;
      end else begin
        if (prev_stall) begin
          checkOutput("stall_valid_held", 32'(lcd_valid), 32'd1);
          checkOutput("stall_inst_held", 32'(lcd_inst), 32'(prev_inst));
        end
        if (prev_ack != 0) checkOutput("ack_one_cycle", 32'(req_ack), 32'd0);
        if (init_done && !prev_init) begin
          checkOutput("init_wait_cycles", 32'(zero_run), 32'(CW));
          checkOutput("init_busy_low", 32'(busy), 32'd0);
        end
        if (lcd_valid && last_was_clear) begin
          checkOutput("clear_wait_cycles", 32'(zero_run), 32'(CW));
          last_was_clear = 1'b0;
        end
        if (req_ack != 0) begin
          ack_total++;
          if (ackq.size() == 0) checkOutput("ack_unexpected", 32'(req_ack), 32'd0);
          else checkOutput("ack_target", 32'(req_ack), 32'(ackq.pop_front()));
        end
        if (lcd_valid && lcd_ready) begin
          xfer_total++;
          if (expq.size() == 0) begin
            compared++;
            failed++;
            $display("[TB] FAIL xfer_unexpected: got 0x%0h, want no transfer", lcd_inst);
          end else begin
            exp_inst = expq.pop_front();
            checkOutput("lcd_inst", 32'(lcd_inst), 32'(exp_inst));
          end
          if (lcd_inst == 9'h001) begin
            msg_char_cnt = 0;
            if (init_done) last_was_clear = 1'b1;
          end else if (lcd_inst[8]) begin
            msg_char_cnt++;
          end
          zero_run = 0;
        end else if (!lcd_valid) begin
          zero_run++;
        end
        prev_stall = lcd_valid && !lcd_ready;
        prev_inst = lcd_inst;
        prev_ack = req_ack;
        prev_init = init_done;
      end
    end
  end

  // Hard stop in case a wait is never satisfied despite the per-wait budgets.
  initial begin
    #2000000;
    failed++;
    $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    int base;
    int ack_before;

    vecs[0] = '{1, 1, 3'b010};
    vecs[1] = '{0, 0, 3'b001};
    vecs[2] = '{2, 3, 3'b100};
    vecs[3] = '{1, 2, 3'b010};
    vecs[4] = '{2, 0, 3'b100};

    // Power-up: asynchronous reset values, then the init sequence.
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_valid", 32'(lcd_valid), 32'd0);
    checkOutput("rst_inst", 32'(lcd_inst), 32'h000);
    checkOutput("rst_ack", 32'(req_ack), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_init_done", 32'(init_done), 32'd0);
    pushInit();
    @(posedge clk); #1;
    rst_n = 1'b1;
    waitInit("pu");
    checkOutput("pu_busy", 32'(busy), 32'd0);

    // Round-robin with all three requests held: order 0, 1, 2, 0.
    $display("[TB] round-robin");
    base = ack_total;
    pushMessage(0, 3'b001);
    pushMessage(2, 3'b010);
    pushMessage(3, 3'b100);
    pushMessage(0, 3'b001);
    @(posedge clk); #1;
    req_msg = {2'd3, 2'd2, 2'd0};
    req = 3'b111;
    waitAcks(base + 3, "rr3");
    waitBusy("rr4");
    req = 3'b000;
    waitAcks(base + 4, "rr4");
    repeat (5) @(negedge clk);
    #1;
    checkOutput("rr_idle_after", 32'(busy), 32'd0);

    // Table of single requests.
    $display("[TB] single-request table");
    for (int v = 0; v < 5; v++) begin
      base = ack_total;
      applyStimulus(vecs[v].req_idx, vecs[v].msg_id, vecs[v].exp_ack, 1'b1, 1'b1);
      waitAcks(base + 1, "vec");
    end

    // Backpressure on the STOPPED message: exactly 17 transfers.
    $display("[TB] backpressure");
    base = ack_total;
    ack_before = xfer_total;
    rand_mode = 1'b1;
    applyStimulus(2, 3, 3'b100, 1'b1, 1'b1);
    waitAcks(base + 1, "bp");
    rand_mode = 1'b0;
    checkOutput("bp_transfers", 32'(xfer_total - ack_before), 32'd17);

    // Requester drops its request after the third character; message still completes.
    $display("[TB] request drop");
    base = ack_total;
    applyStimulus(0, 1, 3'b001, 1'b1, 1'b0);
    waitChars(3, "drop");
    req[0] = 1'b0;
    waitAcks(base + 1, "drop");

    // Reset in the middle of a message: immediate reset values, init restarts, no ack.
    $display("[TB] reset mid-message");
    applyStimulus(1, 2, 3'b010, 1'b1, 1'b0);
    waitChars(5, "mid");
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(lcd_valid), 32'd0);
    checkOutput("mid_rst_inst", 32'(lcd_inst), 32'h000);
    checkOutput("mid_rst_busy", 32'(busy), 32'd1);
    checkOutput("mid_rst_init_done", 32'(init_done), 32'd0);
    checkOutput("mid_rst_ack", 32'(req_ack), 32'd0);
    req = 3'b000;
    expq.delete();
    ackq.delete();
    ack_before = ack_total;
    repeat (3) @(negedge clk);
    pushInit();
    @(posedge clk); #1;
    rst_n = 1'b1;
    waitInit("mid");
    repeat (3) @(negedge clk);
    #1;
    checkOutput("mid_no_ack", 32'(ack_total), 32'(ack_before));
    checkOutput("mid_busy_idle", 32'(busy), 32'd0);

    // Everything expected has been seen.
    checkOutput("expq_drained", 32'(expq.size()), 32'd0);
    checkOutput("ackq_drained", 32'(ackq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
